// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: N_OUT parallel MAC lanes fed one activation per handshake,
// weight rows from an external sync ROM. Optional build macro FC_RELU_EN clamps negative outputs to 0.
module fc_layer_stream #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 64,
  parameter int N_OUT  = 10,
  parameter int ACC_W  = 40,
  parameter int FRAC   = 8,
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic [AW-1:0]             w_addr,
  input  logic [N_OUT*DATA_W-1:0]   w_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*DATA_W-1:0]   out_data,
  output logic [N_OUT-1:0]          out_sat
);

  typedef enum logic [1:0] {RUN, DRAIN, PACK, OUT} state_t;

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state, state_nxt;
  logic [AW-1:0]              cnt;
  logic                       accept, out_fire, last;
  logic signed [DATA_W-1:0]   x_p0;
  logic                       vld_p0;
  logic signed [ACC_W-1:0]    acc [N_OUT];
  logic signed [2*DATA_W-1:0] prod [N_OUT];
  logic signed [DATA_W-1:0]   pk_data [N_OUT];
  logic [N_OUT-1:0]           pk_sat;

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    return a >>> FRAC;
  endfunction

  function automatic logic clamped(input logic signed [ACC_W-1:0] s);
    return (s > MAXV) || (s < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] s);
    if (s > MAXV)      return MAXV[DATA_W-1:0];
    else if (s < MINV) return MINV[DATA_W-1:0];
    else               return s[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == AW'(N_IN - 1));
  assign w_addr   = cnt;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && last) state_nxt = DRAIN;
      DRAIN:   state_nxt = PACK;
      PACK:    state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      vld_p0    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= accept;
      if (accept) cnt <= last ? '0 : cnt + 1'b1;
      if (state == PACK)  out_valid <= 1'b1;
      else if (out_fire)  out_valid <= 1'b0;
    end
  end

  // p0: capture activation; the ROM row for the same index arrives alongside it
  always_ff @(posedge clk) begin
    if (accept) x_p0 <= $signed(in_data);
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      prod[j] = {{DATA_W{x_p0[DATA_W-1]}}, x_p0} *
                {{DATA_W{w_rdata[j*DATA_W+DATA_W-1]}}, w_rdata[j*DATA_W +: DATA_W]};
    end
  end

  // p1: accumulate; PACK empties the lanes so the next vector starts from zero
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++) begin
      if (rst || state == PACK)
        acc[j] <= '0;
      else if (vld_p0)
        acc[j] <= acc[j] + {{(ACC_W-2*DATA_W){prod[j][2*DATA_W-1]}}, prod[j]};
    end
  end

  always_comb begin
    pk_sat = '0;
    for (int j = 0; j < N_OUT; j++) begin
      pk_sat[j] = clamped(scale(acc[j]));
`ifdef FC_RELU_EN
      pk_data[j] = relu(saturate(scale(acc[j])));
`else
      pk_data[j] = saturate(scale(acc[j]));
`endif
    end
  end

  // p2: result register, held until downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sat  <= '0;
    end else if (state == PACK) begin
      out_sat <= pk_sat;
      for (int j = 0; j < N_OUT; j++) out_data[j*DATA_W +: DATA_W] <= pk_data[j];
    end
  end

endmodule
